// File: rtl/conv_pkg.sv
// Shared constants, pixel type and width helper for the convolution window path.
package conv_pkg;

  localparam int unsigned CONV_K       = 3;
  localparam int unsigned CONV_D_WIDTH = 8;
  localparam int unsigned WIN_ELEMS    = CONV_K * CONV_K;

  typedef logic signed [CONV_D_WIDTH-1:0] pixel_t;

  // Bits needed to index n distinct values (n >= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned v;
    int unsigned r;
    v = (n > 0) ? n - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_window_buffer_line_buffer.sv
// Fixed-depth delay line that advances one slot per shift enable.
module line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pixel storage only; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (i_shift_en) begin
      r_mem[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-order KxK sliding-window generator with a one-entry output skid.
// Optional CONV_WINDOW_FRAME_END_EN adds frame_last, flagging the final window of a frame.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int unsigned K          = CONV_K,
  parameter int unsigned D_WIDTH    = CONV_D_WIDTH,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D_WIDTH-1:0]           in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [D_WIDTH*K*K-1:0]       out_window,
  output logic [clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [clog2(IMG_WIDTH)-1:0]  out_col
`ifdef CONV_WINDOW_FRAME_END_EN
  ,
  output logic                         frame_last
`endif
);

  localparam int unsigned ROW_W = clog2(IMG_HEIGHT);
  localparam int unsigned COL_W = clog2(IMG_WIDTH);
  localparam int unsigned NLB   = K - 1;

  logic                   w_accept;
  logic                   w_emit;
  logic                   w_col_last;
  logic                   w_row_last;
  logic [ROW_W-1:0]       r_row;
  logic [COL_W-1:0]       r_col;
  logic [D_WIDTH-1:0]     w_lb_in    [NLB];
  logic [D_WIDTH-1:0]     w_lb_out   [NLB];
  logic [D_WIDTH-1:0]     w_col_new  [K];
  logic [D_WIDTH-1:0]     r_win      [K][K];
  logic [D_WIDTH-1:0]     w_win_next [K][K];
  logic [D_WIDTH*K*K-1:0] w_flat;

  assign in_ready   = !out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_emit     = w_accept && (r_row >= ROW_W'(K - 1)) && (r_col >= COL_W'(K - 1));

  // Line buffer j delivers the pixel (j+1) rows above the incoming one.
  for (genvar j = 0; j < NLB; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign w_lb_in[j] = in_data;
    end else begin : g_tail
      assign w_lb_in[j] = w_lb_out[j-1];
    end
    line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (D_WIDTH)
    ) u_line_buffer (
      .clk        (clk),
      .i_shift_en (w_accept),
      .i_data     (w_lb_in[j]),
      .o_data     (w_lb_out[j])
    );
  end

  // New rightmost column, oldest row at index 0.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      w_col_new[r] = in_data;
    end
    for (int unsigned r = 0; r < NLB; r++) begin
      w_col_new[r] = w_lb_out[NLB-1-r];
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) begin
        w_win_next[r][c] = r_win[r][c+1];
      end
      w_win_next[r][K-1] = w_col_new[r];
    end
  end

  always_comb begin
    w_flat = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        w_flat[D_WIDTH*(r*K+c) +: D_WIDTH] = w_win_next[r][c];
      end
    end
  end

  // Window storage; only trusted once a full KxK region has been shifted in.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_win <= w_win_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Output skid: hold under backpressure, refill on the same cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else if (w_emit) begin
      out_valid  <= 1'b1;
      out_window <= w_flat;
      out_row    <= r_row - ROW_W'(K - 1);
      out_col    <= r_col - COL_W'(K - 1);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef CONV_WINDOW_FRAME_END_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_last <= 1'b0;
    end else if (w_emit) begin
      frame_last <= w_row_last && w_col_last;
    end else if (out_ready) begin
      frame_last <= 1'b0;
    end
  end
`endif

endmodule
